// File: rtl/tdm_demux16_pkg.sv
// Shared types and constants for the 16-slot TDM demultiplexer.
// Slot count, select width, FSM states and the parity helper live here.
package tdm_demux_pkg;

  localparam int N_CH  = 16;
  localparam int SEL_W = 4;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_CH-1:0]  word_t;

  localparam sel_t SEL_LAST = sel_t'(N_CH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2
  } state_t;

  // Even parity: the parity bit equals the XOR of all data bits.
  function automatic logic even_parity(input word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/tdm_demux16_if.sv
// Serial-in / parallel-out bundle of the TDM demultiplexer.
// master drives the serial side; slave is the demultiplexer itself.
interface tdm_demux16_if;
  import tdm_demux_pkg::*;

  logic  in;
  logic  in_valid;
  logic  sync;
  word_t out;
  logic  out_valid;
  sel_t  sel;
  logic  busy;
  logic  err;

  modport master (
    output in, in_valid, sync,
    input  out, out_valid, sel, busy, err
  );

  modport slave (
    input  in, in_valid, sync,
    output out, out_valid, sel, busy, err
  );

endinterface

// File: rtl/tdm_demux16_slot_decoder.sv
// One-hot slot write-enable decoder, gated by a write strobe.
// Purely combinational; no enable is raised while stb is low.
module slot_decoder #(
  parameter int SEL_W = 4,
  parameter int N_CH  = 16
) (
  input  logic [SEL_W-1:0] idx,
  input  logic             stb,
  output logic [N_CH-1:0]  wen
);

  always_comb begin
    wen = '0;
    if (stb) wen[idx] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux16.sv
// Serial TDM demux: one bit per valid cycle into slot sel, word out one cycle after slot 15 (TDM_DEMUX_PARITY_EN adds a checked parity bit).
// No backpressure: in_valid gaps simply hold state; early sync discards the partial frame with an err pulse.
module tdm_demux16
  import tdm_demux_pkg::*;
(
  input logic          clk,
  input logic          rst,
  tdm_demux16_if.slave bus
);

  state_t state, state_nxt;
  sel_t   sel_q, sel_nxt;
  word_t  shadow, shadow_nxt;
  word_t  out_q, out_nxt;
  logic   ov_q, ov_nxt;
  logic   err_q, err_nxt;

  logic   wr_stb;
  sel_t   wr_idx;
  word_t  wen;

  slot_decoder #(
    .SEL_W (SEL_W),
    .N_CH  (N_CH)
  ) u_slot_decoder (
    .idx (wr_idx),
    .stb (wr_stb),
    .wen (wen)
  );

  // Only the addressed slot takes the incoming bit; stale slots are kept.
  assign shadow_nxt = (shadow & ~wen) | ({N_CH{bus.in}} & wen);

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    out_nxt   = out_q;
    ov_nxt    = 1'b0;
    err_nxt   = 1'b0;
    wr_stb    = 1'b0;
    wr_idx    = sel_q;

    if (bus.in_valid) begin
      unique case (state)
        IDLE: begin
          if (bus.sync) begin
            wr_stb    = 1'b1;
            wr_idx    = '0;
            sel_nxt   = sel_t'(1);
            state_nxt = COLLECT;
          end
        end

        COLLECT: begin
          if (bus.sync && (sel_q != '0)) begin
            err_nxt = 1'b1;
            wr_stb  = 1'b1;
            wr_idx  = '0;
            sel_nxt = sel_t'(1);
          end else begin
            wr_stb  = 1'b1;
            wr_idx  = sel_q;
            sel_nxt = sel_q + sel_t'(1);
            if (sel_q == SEL_LAST) begin
`ifdef TDM_DEMUX_PARITY_EN
              state_nxt = PARITY;
`else
              out_nxt   = {bus.in, shadow[N_CH-2:0]};
              ov_nxt    = 1'b1;
              state_nxt = IDLE;
`endif
            end
          end
        end

`ifdef TDM_DEMUX_PARITY_EN
        PARITY: begin
          if (bus.sync) begin
            err_nxt   = 1'b1;
            wr_stb    = 1'b1;
            wr_idx    = '0;
            sel_nxt   = sel_t'(1);
            state_nxt = COLLECT;
          end else begin
            state_nxt = IDLE;
            if (bus.in == even_parity(shadow)) begin
              out_nxt = shadow;
              ov_nxt  = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
`endif

        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel_q  <= '0;
      shadow <= '0;
      out_q  <= '0;
      ov_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      sel_q  <= sel_nxt;
      shadow <= shadow_nxt;
      out_q  <= out_nxt;
      ov_q   <= ov_nxt;
      err_q  <= err_nxt;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = ov_q;
  assign bus.err       = err_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: doc/tdm_demux16.md
# tdm_demux16

Serial time-division demultiplexer: the receive end of the 16-channel scanning multiplexer datapath. Accepts one bit per valid cycle on a 1-bit line, steers each bit into the slot addressed by an internal select counter, and presents the completed 16-bit word in parallel with a one-cycle valid pulse. It sits between a serialised link, whose transmitter walks `sel` 0→15 through a 16-to-1 mux, and parallel consumer logic.

## Interface
Parameters:
- `N_CH`, 16: number of channels (slots) per frame.
- `SEL_W`, 4: select/counter width, equal to clog2(N_CH).

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk`, input, 1: sole clock; all state updates on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in`, input, 1: serial data bit.
- `in_valid`, input, 1: `in` (and `sync`) sampled only when high.
- `sync`, input, 1: frame start; qualifies the current `in` bit as slot 0.
- `out`, output, N_CH: last completed frame; bit k = slot k.
- `out_valid`, output, 1: one-cycle pulse, new frame on `out`.
- `sel`, output, SEL_W: slot index the next valid bit will be written to.
- `busy`, output, 1: high while a frame is being collected.
- `err`, output, 1: one-cycle pulse on a frame error.

## Operation
- Reset values:
  - `out` = 0, `out_valid` = 0, `sel` = 0, `busy` = 0, `err` = 0.
  - Internal shadow register = 0; state = IDLE.
- States: IDLE, COLLECT, plus PARITY when `TDM_DEMUX_PARITY_EN` is defined.
- IDLE:
  - Bits with `in_valid`=1 and `sync`=0 are ignored.
  - `in_valid`=1 with `sync`=1: write `in` to shadow[0], set `sel` = 1, go to COLLECT.
- COLLECT:
  - Each `in_valid`=1 cycle writes `in` to shadow[`sel`] and increments `sel`.
  - `in_valid`=0: all state holds; gaps are unlimited.
- Frame completion: when the written slot is N_CH-1 (15):
  - `out` <= {in, shadow[14:0]}, `out_valid` <= 1.
  - `sel` wraps to 0; state returns to IDLE.
- Frame ends on the same cycle as a new sync: the completion edge is the slot-15 bit itself, so the next frame's `sync` is legal on the very next valid cycle, with no idle gap required.
- Early sync: `sync`=1 with `in_valid`=1 while in COLLECT and `sel` ≠ 0:
  - `err` pulses.
  - The partial frame is discarded (`out` unchanged, no `out_valid`).
  - The current bit becomes slot 0 of a new frame, and `sel` = 1.
- Unused slot bits of the shadow are not cleared between frames; only fully written frames reach `out`.
- `out` holds its value until the next successful completion.
- `busy` = 1 exactly when state ≠ IDLE.
- Reset mid-frame: asynchronous clear to reset values; the partial frame is lost and no `out_valid` is issued.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: `out_valid` and the new `out` are visible in the cycle after the edge sampling slot 15.
- Minimum frame period is 16 valid cycles (back-to-back frames, `out_valid` every 16th cycle).
- `err` and `out_valid` are never high in the same cycle.

## Configuration
- Macro: `TDM_DEMUX_PARITY_EN`.
- Defined:
  - After slot 15, the state goes to PARITY instead of completing.
  - The next valid bit is the even-parity bit over the 16 data bits. Match: update `out`, pulse `out_valid`. Mismatch: pulse `err`, leave `out` unchanged.
  - Then return to IDLE. Latency grows by one valid cycle; the frame is 17 bits.
  - `sync` during PARITY is treated as an early sync.
- Undefined: no PARITY state; the frame is 16 bits as above.

## Structure
- Package `tdm_demux_pkg`:
  - State enum (IDLE, COLLECT, PARITY).
  - Constants `N_CH`=16, `SEL_W`=4.
- Sub-module `slot_decoder`: SEL_W-to-N_CH one-hot write-enable decoder, gated by a write strobe. It drives the shadow register bit enables.

## Test plan
- Reset, then send 16'h3f0a LSB-first with `sync` on bit 0 and `in_valid` continuous. Required: `out`=16'h3f0a, `out_valid` high for exactly one cycle after the 16th bit, `busy` falls at the same edge.
- Same frame with `in_valid` deasserted for 3 cycles after slots 5 and 11. Required: `out`=16'h3f0a, with `out_valid` delayed by 6 cycles.
- Send 8 bits of one frame, then a new `sync` frame of 16'hA5A5. Required: `err` pulses once at the sync, then `out`=16'hA5A5; no `out_valid` is issued for the partial frame.
- Two back-to-back frames 16'h0001 then 16'h8000. Required: two `out_valid` pulses exactly 16 cycles apart, with `out` following those values.
- Assert `rst` at slot 9 of a frame, then send a full frame of 16'h1234. Required: all outputs are 0 during reset, no spurious `out_valid`, and then `out`=16'h1234.
- With `TDM_DEMUX_PARITY_EN` defined, send 16'h0003 with parity bit 0, then with parity bit 1. Required: the first gives `out`=16'h0003 with `out_valid`; the second gives an `err` pulse with `out` still 16'h0003.
